// File: rtl/conv2d_adder_sched.sv
// ---------------------------------------------------------------------------
// conv2d_adder_sched
//
// Sequencer for a 16-lane conv2d adder bank. It walks one output feature map
// in row -> col -> group order (group innermost), firing one adder pass per
// step and handing every 16-lane sum to writeback with a result tag.
//
// Optional feature: define ADDER_TIMEOUT_EN to add a watchdog on the adder.
// If no adder_valid arrives within TMO_CYC cycles of FIRE, the map is
// aborted and err_timeout_o is set. Without the macro, WAIT_SUM waits forever
// and err_timeout_o is tied to 0.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   cfg_start_i              1-cycle start pulse, accepted only in IDLE
//   cfg_width_i/height_i     output columns/rows (0 behaves as 1)
//   cfg_groups_i             filter groups minus 1
//   busy_o, done_o           map in progress / 1-cycle completion pulse
//   prod_valid_i, prod_ack_o MAC products ready / products consumed
//   start_adder_o            1-cycle kick to the adder bank
//   bias_sel_o               bias bank index (current group)
//   adder_valid_i            AND of the 16 lane valids
//   out_valid_o/out_ready_i  result handshake toward writeback
//   out_row_o/col_o/grp_o    result tag
//   err_timeout_o            sticky adder watchdog flag
//   dbg_state_o              current FSM state encoding
//
// Handshake: a result transfers on a rising edge where out_valid_o and
// out_ready_i are both high. Once raised, out_valid_o and the tags stay
// constant until that transfer; out_valid_o never depends on out_ready_i.
// ---------------------------------------------------------------------------
module conv2d_adder_sched #(
    parameter int DIM_W = 8,
    parameter int GRP_W = 4
`ifdef ADDER_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 64
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_start_i,
    input  logic [DIM_W-1:0] cfg_width_i,
    input  logic [DIM_W-1:0] cfg_height_i,
    input  logic [GRP_W-1:0] cfg_groups_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             prod_valid_i,
    output logic             prod_ack_o,
    output logic             start_adder_o,
    output logic [GRP_W-1:0] bias_sel_o,
    input  logic             adder_valid_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DIM_W-1:0] out_row_o,
    output logic [DIM_W-1:0] out_col_o,
    output logic [GRP_W-1:0] out_grp_o,
    output logic             err_timeout_o,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PROD = 3'd1,
        S_FIRE      = 3'd2,
        S_WAIT_SUM  = 3'd3,
        S_EMIT      = 3'd4,
        S_DONE      = 3'd5
    } state_e;

    state_e           state_q;
    logic [DIM_W-1:0] row_q, col_q, w_last_q, h_last_q;
    logic [GRP_W-1:0] grp_q, g_last_q;
    logic             busy_q, done_q, ack_q, start_q, out_valid_q;

    logic [DIM_W-1:0] row_d, col_d;
    logic [GRP_W-1:0] grp_d;
    logic             last_step;

`ifdef ADDER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
`endif

    // Next position in row -> col -> group order. After the last step the
    // counters return to zero so the tags read 0 while idle.
    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        grp_d     = grp_q;
        last_step = (row_q == h_last_q) && (col_q == w_last_q) && (grp_q == g_last_q);
        if (grp_q == g_last_q) begin
            grp_d = '0;
            if (col_q == w_last_q) begin
                col_d = '0;
                row_d = row_q + DIM_W'(1);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end else begin
            grp_d = grp_q + GRP_W'(1);
        end
        if (last_step) begin
            row_d = '0;
            col_d = '0;
            grp_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            grp_q       <= '0;
            w_last_q    <= '0;
            h_last_q    <= '0;
            g_last_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ADDER_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            // Single-cycle pulses default low.
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_start_i) begin
                        // Store last indices so a zero dimension behaves as 1.
                        w_last_q <= (cfg_width_i  == '0) ? '0 : cfg_width_i  - DIM_W'(1);
                        h_last_q <= (cfg_height_i == '0) ? '0 : cfg_height_i - DIM_W'(1);
                        g_last_q <= cfg_groups_i;
                        row_q    <= '0;
                        col_q    <= '0;
                        grp_q    <= '0;
                        busy_q   <= 1'b1;
`ifdef ADDER_TIMEOUT_EN
                        err_q    <= 1'b0;
`endif
                        state_q  <= S_WAIT_PROD;
                    end
                end
                S_WAIT_PROD: begin
                    if (prod_valid_i) begin
                        start_q <= 1'b1;
                        ack_q   <= 1'b1;
                        state_q <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    // adder_valid during FIRE is stale and deliberately ignored.
`ifdef ADDER_TIMEOUT_EN
                    tmo_q   <= TMO_W'(1);
`endif
                    state_q <= S_WAIT_SUM;
                end
                S_WAIT_SUM: begin
                    if (adder_valid_i) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_EMIT;
                    end
`ifdef ADDER_TIMEOUT_EN
                    // tmo_q counts cycles since FIRE; abort lands in IDLE
                    // exactly TMO_CYC cycles after FIRE.
                    else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                S_EMIT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        row_q       <= row_d;
                        col_q       <= col_d;
                        grp_q       <= grp_d;
                        if (last_step) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT_PROD;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign prod_ack_o    = ack_q;
    assign start_adder_o = start_q;
    assign bias_sel_o    = grp_q;
    assign out_valid_o   = out_valid_q;
    assign out_row_o     = row_q;
    assign out_col_o     = col_q;
    assign out_grp_o     = grp_q;
    assign dbg_state_o   = state_q;
`ifdef ADDER_TIMEOUT_EN
    assign err_timeout_o = err_q;
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule
